// File: rtl/rvfi_trace_fifo.sv
// Capture FIFO for RVFI retirement records, with drop accounting
// and a retirement-order continuity checker.
module rvfi_trace_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     capture_en_i,
   input  logic                     clear_i,
   input  logic                     rvfi_valid,
   input  logic [63:0]              rvfi_order,
   input  logic [31:0]              rvfi_insn,
   input  logic [31:0]              rvfi_pc_rdata,
   input  logic [31:0]              rvfi_pc_wdata,
   input  logic [4:0]               rvfi_rd_addr,
   input  logic [31:0]              rvfi_rd_wdata,
   input  logic                     rvfi_trap,
   output logic                     trc_valid_o,
   input  logic                     trc_ready_i,
   output logic [63:0]              trc_order_o,
   output logic [31:0]              trc_insn_o,
   output logic [31:0]              trc_pc_o,
   output logic [31:0]              trc_npc_o,
   output logic [4:0]               trc_rd_addr_o,
   output logic [31:0]              trc_rd_wdata_o,
   output logic                     trc_trap_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [15:0]              drop_cnt_o,
   output logic                     overflow_o,
   output logic                     order_err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   typedef struct packed {
      logic [63:0] order;
      logic [31:0] insn;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic        trap;
   } entry_t;

   typedef enum logic [1:0] {SEEK, TRACK, ERR} ord_st_e;

   entry_t        mem_q [DEPTH];
   entry_t        wr_entry;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   drop_q;
   logic          ovf_q;
   ord_st_e       st_q;
   logic [63:0]   last_q;
   logic          err_q;

   logic full, cap, push, pop, drop;

   assign full = (cnt_q == FULL_C);
   assign cap  = rvfi_valid & capture_en_i & ~clear_i;
   assign pop  = trc_valid_o & trc_ready_i & ~clear_i;
   assign push = cap & (~full | pop);
   assign drop = cap & full & ~pop;

   assign wr_entry.order = rvfi_order;
   assign wr_entry.insn  = rvfi_insn;
   assign wr_entry.pc    = rvfi_pc_rdata;
   assign wr_entry.npc   = rvfi_pc_wdata;
   assign wr_entry.rd    = rvfi_rd_addr;
   assign wr_entry.wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
   assign wr_entry.trap  = rvfi_trap;

   // Entry storage; contents are don't-care until pushed, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= wr_entry;
   end

   // Pointers and occupancy; clear flushes everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
   end

   // Saturating drop counter and sticky overflow flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else if (clear_i) begin
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else if (drop) begin
         if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         ovf_q <= 1'b1;
      end
   end

   // Order checker: sees every retirement, even uncaptured ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q   <= SEEK;
         last_q <= '0;
         err_q  <= 1'b0;
      end else if (clear_i) begin
         st_q  <= SEEK;
         err_q <= 1'b0;
      end else if (rvfi_valid) begin
         last_q <= rvfi_order;
         unique case (st_q)
            SEEK: begin
               st_q  <= TRACK;
               err_q <= 1'b0;
            end
            TRACK: begin
               if (rvfi_order != last_q + 64'd1) begin
                  st_q  <= ERR;
                  err_q <= 1'b1;
               end
            end
            default: begin
               st_q  <= ERR;
               err_q <= 1'b1;
            end
         endcase
      end
   end

   assign trc_valid_o    = (cnt_q != '0);
   assign trc_order_o    = mem_q[rptr_q].order;
   assign trc_insn_o     = mem_q[rptr_q].insn;
   assign trc_pc_o       = mem_q[rptr_q].pc;
   assign trc_npc_o      = mem_q[rptr_q].npc;
   assign trc_rd_addr_o  = mem_q[rptr_q].rd;
   assign trc_rd_wdata_o = mem_q[rptr_q].wdata;
   assign trc_trap_o     = mem_q[rptr_q].trap;
   assign count_o        = cnt_q;
   assign drop_cnt_o     = drop_q;
   assign overflow_o     = ovf_q;
   assign order_err_o    = err_q;

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Bench for rvfi_trace_fifo: vector table plus corner sequences,
// head entries scored against a queue of expected records.
module tb_rvfi_trace_fifo;

   localparam int DEPTH = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        capture_en_i = 1'b0;
   logic        clear_i = 1'b0;
   logic        rvfi_valid = 1'b0;
   logic [63:0] rvfi_order = '0;
   logic [31:0] rvfi_insn = '0;
   logic [31:0] rvfi_pc_rdata = '0;
   logic [31:0] rvfi_pc_wdata = '0;
   logic [4:0]  rvfi_rd_addr = '0;
   logic [31:0] rvfi_rd_wdata = '0;
   logic        rvfi_trap = 1'b0;
   logic        trc_valid_o;
   logic        trc_ready_i = 1'b0;
   logic [63:0] trc_order_o;
   logic [31:0] trc_insn_o;
   logic [31:0] trc_pc_o;
   logic [31:0] trc_npc_o;
   logic [4:0]  trc_rd_addr_o;
   logic [31:0] trc_rd_wdata_o;
   logic        trc_trap_o;
   logic [4:0]  count_o;
   logic [15:0] drop_cnt_o;
   logic        overflow_o;
   logic        order_err_o;

   rvfi_trace_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .capture_en_i(capture_en_i), .clear_i(clear_i),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
      .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
      .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_rd_addr(rvfi_rd_addr),
      .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap),
      .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i),
      .trc_order_o(trc_order_o), .trc_insn_o(trc_insn_o),
      .trc_pc_o(trc_pc_o), .trc_npc_o(trc_npc_o),
      .trc_rd_addr_o(trc_rd_addr_o), .trc_rd_wdata_o(trc_rd_wdata_o),
      .trc_trap_o(trc_trap_o), .count_o(count_o),
      .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o),
      .order_err_o(order_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] order;
      logic [31:0] insn;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic        trap;
   } exp_t;

   typedef struct {
      bit          v;
      logic [63:0] ord;
      logic [4:0]  rd;
      logic [31:0] wd;
      bit          rdy;
      bit          cap;
      bit          clr;
      int          exp_cnt;
      bit          exp_err;
   } vec_t;

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_tot = 0;
   int          m_drop = 0;
   bit          m_ovf = 0;
   int          m_st = 0;
   logic [63:0] m_last = '0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      sb.delete();
      m_drop = 0;
      m_ovf  = 0;
      m_st   = 0;
   endtask

   task automatic step(input bit v, input logic [63:0] ord,
                       input logic [4:0] rd, input logic [31:0] wd,
                       input bit rdy, input bit cap, input bit clr);
      exp_t e;
      @(negedge clk_i);
      rvfi_valid    = v;
      rvfi_order    = ord;
      rvfi_insn     = ord[31:0] ^ 32'h0000_0013;
      rvfi_pc_rdata = {ord[29:0], 2'b00};
      rvfi_pc_wdata = {ord[29:0], 2'b00} + 32'd4;
      rvfi_rd_addr  = rd;
      rvfi_rd_wdata = wd;
      rvfi_trap     = ord[3];
      trc_ready_i   = rdy;
      capture_en_i  = cap;
      clear_i       = clr;
      #1;
      chk("trc_valid", trc_valid_o, sb.size() != 0);
      if (sb.size() != 0) begin
         chk("head_order", trc_order_o, sb[0].order);
         chk("head_insn", trc_insn_o, sb[0].insn);
         chk("head_pc", trc_pc_o, sb[0].pc);
         chk("head_npc", trc_npc_o, sb[0].npc);
         chk("head_rd", trc_rd_addr_o, sb[0].rd);
         chk("head_wdata", trc_rd_wdata_o, sb[0].wdata);
         chk("head_trap", trc_trap_o, sb[0].trap);
      end
      if (clr) begin
         model_reset();
      end else begin
         if (rdy && sb.size() != 0) void'(sb.pop_front());
         if (v && cap) begin
            if (sb.size() < DEPTH) begin
               e.order = ord;
               e.insn  = ord[31:0] ^ 32'h0000_0013;
               e.pc    = {ord[29:0], 2'b00};
               e.npc   = {ord[29:0], 2'b00} + 32'd4;
               e.rd    = rd;
               e.wdata = (rd == 5'd0) ? 32'd0 : wd;
               e.trap  = ord[3];
               sb.push_back(e);
            end else begin
               if (m_drop < 65535) m_drop++;
               m_ovf = 1;
            end
         end
         if (v) begin
            if (m_st == 0) m_st = 1;
            else if (m_st == 1 && ord != m_last + 64'd1) m_st = 2;
            m_last = ord;
         end
      end
      @(posedge clk_i);
      #1;
      chk("count", count_o, sb.size());
      chk("drop_cnt", drop_cnt_o, m_drop);
      chk("overflow", overflow_o, m_ovf);
      chk("order_err", order_err_o, m_st == 2);
   endtask

   vec_t vt[12];

   initial begin
      vt[0]  = '{1, 0, 5'd1, 32'h11, 0, 1, 0, 1, 0};
      vt[1]  = '{1, 1, 5'd2, 32'h22, 0, 1, 0, 2, 0};
      vt[2]  = '{1, 2, 5'd3, 32'h33, 0, 1, 0, 3, 0};
      vt[3]  = '{0, 0, 5'd0, 32'h0,  1, 1, 0, 2, 0};
      vt[4]  = '{0, 0, 5'd0, 32'h0,  1, 1, 0, 1, 0};
      vt[5]  = '{0, 0, 5'd0, 32'h0,  1, 1, 0, 0, 0};
      vt[6]  = '{1, 3, 5'd0, 32'hDEADBEEF, 0, 1, 0, 1, 0};
      vt[7]  = '{0, 0, 5'd0, 32'h0,  1, 1, 0, 0, 0};
      vt[8]  = '{1, 4, 5'd7, 32'h44, 0, 0, 0, 0, 0};
      vt[9]  = '{1, 5, 5'd8, 32'h55, 0, 1, 0, 1, 0};
      vt[10] = '{1, 9, 5'd9, 32'h99, 0, 1, 0, 2, 1};
      vt[11] = '{0, 0, 5'd0, 32'h0,  0, 1, 1, 0, 0};

      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_count", count_o, 0);
      chk("rst_valid", trc_valid_o, 0);
      chk("rst_drop", drop_cnt_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_err", order_err_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(vt[i].v, vt[i].ord, vt[i].rd, vt[i].wd,
              vt[i].rdy, vt[i].cap, vt[i].clr);
         chk($sformatf("vec%0d_count", i), count_o, vt[i].exp_cnt);
         chk($sformatf("vec%0d_err", i), order_err_o, vt[i].exp_err);
      end

      for (int i = 0; i < 18; i++)
         step(1, 64'd100 + 64'(i), 5'd4, 32'h1000 + 32'(i), 0, 1, 0);
      chk("ovf_count", count_o, 16);
      chk("ovf_drop", drop_cnt_o, 2);
      chk("ovf_flag", overflow_o, 1);
      chk("ovf_err", order_err_o, 0);
      chk("ovf_head", trc_order_o, 100);

      step(1, 64'd118, 5'd4, 32'h2000, 1, 1, 0);
      chk("fullpp_count", count_o, 16);
      chk("fullpp_drop", drop_cnt_o, 2);
      chk("fullpp_head", trc_order_o, 101);

      for (int i = 0; i < 16; i++)
         step(0, 0, 5'd0, 32'h0, 1, 1, 0);
      chk("drain_count", count_o, 0);
      step(0, 0, 5'd0, 32'h0, 0, 1, 1);

      step(1, 64'd5, 5'd1, 32'h5, 1, 1, 0);
      step(1, 64'd6, 5'd1, 32'h6, 1, 1, 0);
      chk("seq_err_pre", order_err_o, 0);
      step(1, 64'd8, 5'd1, 32'h8, 1, 1, 0);
      chk("seq_err_set", order_err_o, 1);
      step(1, 64'd9, 5'd1, 32'h9, 1, 1, 0);
      chk("seq_err_hold", order_err_o, 1);
      step(0, 0, 5'd0, 32'h0, 1, 1, 1);
      chk("seq_err_clr", order_err_o, 0);

      for (int i = 0; i < 7; i++)
         step(1, 64'd200 + 64'(i), 5'd2, 32'h3000, 0, 1, 0);
      chk("pre_rst_count", count_o, 7);
      @(negedge clk_i);
      rvfi_valid  = 1'b0;
      trc_ready_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_count", count_o, 0);
      chk("mid_rst_valid", trc_valid_o, 0);
      chk("mid_rst_drop", drop_cnt_o, 0);
      chk("mid_rst_err", order_err_o, 0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step(1, 64'd300, 5'd3, 32'hABCD, 0, 1, 0);
      step(0, 0, 5'd0, 32'h0, 1, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/rvfi_trace_fifo.md
RVFI_TRACE_FIFO -- requirements
Module: rvfi_trace_fifo

Interface
REQ-001 DEPTH, default 16, number of trace entries; SHALL be a power of two >= 2.
REQ-002 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 capture_en_i  input  1  high enables capture of retirements.
REQ-005 clear_i  input  1  synchronous flush of FIFO and status.
REQ-006 rvfi_valid  input  1  retirement strobe from dtcore32.
REQ-007 rvfi_order  input  64  retirement index.
REQ-008 rvfi_insn  input  32  retired instruction word.
REQ-009 rvfi_pc_rdata  input  32  PC of retired instruction.
REQ-010 rvfi_pc_wdata  input  32  next PC.
REQ-011 rvfi_rd_addr  input  5  destination register.
REQ-012 rvfi_rd_wdata  input  32  destination write data.
REQ-013 rvfi_trap  input  1  instruction trapped.
REQ-014 trc_valid_o  output  1  head entry available.
REQ-015 trc_ready_i  input  1  consumer accepts head entry.
REQ-016 trc_order_o  output  64  head order.
REQ-017 trc_insn_o  output  32  head instruction.
REQ-018 trc_pc_o  output  32  head PC.
REQ-019 trc_npc_o  output  32  head next PC.
REQ-020 trc_rd_addr_o  output  5  head rd.
REQ-021 trc_rd_wdata_o  output  32  head rd data.
REQ-022 trc_trap_o  output  1  head trap flag.
REQ-023 count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-024 drop_cnt_o  output  16  retirements lost to full FIFO.
REQ-025 overflow_o  output  1  sticky: at least one drop.
REQ-026 order_err_o  output  1  sticky: rvfi_order discontinuity.

Function
REQ-027 Push SHALL occur when rvfi_valid & capture_en_i & !clear_i & (count_o<DEPTH or pop same cycle).
REQ-028 Pop SHALL occur when trc_valid_o & trc_ready_i & !clear_i.
REQ-029 trc_valid_o SHALL equal (count_o != 0); head fields SHALL come from registered storage, no combinational path from rvfi_* to trc_*; pushed entry visible the cycle after the push.
REQ-030 Head fields SHALL hold stable while trc_valid_o & !trc_ready_i.
REQ-031 Stored rd_wdata SHALL be forced to 0 when rvfi_rd_addr == 0.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH; count_o +1 on push-only, -1 on pop-only, unchanged on both.
REQ-033 Push+pop in the same cycle when full SHALL both occur, no drop; when empty, only push occurs.
REQ-034 Capture attempt while full without pop SHALL discard the record, increment drop_cnt_o (saturating at 0xFFFF), set overflow_o.
REQ-035 capture_en_i low SHALL suppress push and drop counting; pops continue.
REQ-036 Order checker FSM SHALL observe every rvfi_valid regardless of capture_en_i or drops: SEEK (no reference), TRACK, ERR.
REQ-037 SEEK -> TRACK on first rvfi_valid, latching rvfi_order as last.
REQ-038 TRACK: rvfi_valid with order == last+1 (64-bit wrap) updates last; otherwise -> ERR and updates last.
REQ-039 ERR SHALL persist until clear_i or reset; order_err_o = (state == ERR), registered.
REQ-040 clear_i SHALL dominate: count, pointers, drop_cnt_o, overflow_o zeroed, FSM -> SEEK, same-cycle push/pop discarded.

Reset
REQ-041 rst_ni low SHALL immediately force count_o, trc_valid_o, drop_cnt_o, overflow_o, order_err_o, pointers to 0 and FSM to SEEK; storage contents need not reset; trc_* data fields undefined while trc_valid_o = 0.

Verification
REQ-042 Orders 0,1,2 pushed, trc_ready_i=0 -> count_o=3, trc_order_o=0 held; ready=1 three cycles -> orders 0,1,2 out, count_o=0.
REQ-043 DEPTH=16, ready=0, 18 consecutive retirements -> count_o=16, drop_cnt_o=2, overflow_o=1, order_err_o=0, head order 0.
REQ-044 Full FIFO, push and pop same cycle -> count_o stays 16, drop_cnt_o unchanged, new head = old second entry.
REQ-045 Orders 5,6,8 -> order_err_o=1 the cycle after order 8, remains 1 through order 9; clear_i pulse -> 0.
REQ-046 rd_addr=0, rd_wdata=0xDEADBEEF -> trc_rd_wdata_o=0x00000000.
REQ-047 rst_ni asserted mid-stream with count_o=7 -> count_o=0, trc_valid_o=0 before next clock edge.
